reg_read_scoreboard: RTL and testbench

//  Register-read stage for the MIPS pipeline: drives the register file read addresses, tracks in-flight writes with a busy-bit scoreboard, and applies writeback bypass.

---
 rtl/reg_read_scoreboard.sv | 157 +++++++++++++++
 tb/tb_reg_read_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_scoreboard.sv
// Register-read stage with a busy-bit scoreboard, optional writeback bypass and a registered
// valid/ready hand-off to execute. Optional feature macro: RRS_BYPASS_EN (writeback bypass).
module reg_read_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic [AW-1:0]    id_dst,
  input  logic             id_dst_we,
  output logic [AW-1:0]    rf_rs,
  output logic [AW-1:0]    rf_rt,
  input  logic [DW-1:0]    rf_rd1,
  input  logic [DW-1:0]    rf_rd2,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DW-1:0]    wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [DW-1:0]    ex_op1,
  output logic [DW-1:0]    ex_op2,
  output logic [AW-1:0]    ex_dst,
  output logic             ex_dst_we,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StRawWait, StOutWait} state_e;

  state_e            state_q, state_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              ex_valid_q;
  logic [DW-1:0]     ex_op1_q, ex_op2_q;
  logic [AW-1:0]     ex_dst_q;
  logic              ex_dst_we_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              bsy_rs, bsy_rt, bsy_dst;
  logic              eb_rs, eb_rt, eb_dst;
  logic              hit_rs, hit_rt, hit_dst;
  logic [DW-1:0]     op1, op2;
  logic              hazard, out_free, accept, stall;

  function automatic logic reg_busy(input logic [NREG-1:0] b, input logic [AW-1:0] r);
    logic res;
    res = 1'b0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (r == AW'(i)) res = b[i];
    end
    return res;
  endfunction

  assign rf_rs   = id_rs;
  assign rf_rt   = id_rt;
  assign bsy_rs  = reg_busy(busy_q, id_rs);
  assign bsy_rt  = reg_busy(busy_q, id_rt);
  assign bsy_dst = reg_busy(busy_q, id_dst);
  // Register 0 never produces a bypass hit.
  assign hit_rs  = wb_we && (wb_addr == id_rs) && (id_rs != '0);
  assign hit_rt  = wb_we && (wb_addr == id_rt) && (id_rt != '0);
  assign hit_dst = wb_we && (wb_addr == id_dst) && (id_dst != '0);

`ifdef RRS_BYPASS_EN
  assign eb_rs  = bsy_rs & ~hit_rs;
  assign eb_rt  = bsy_rt & ~hit_rt;
  assign eb_dst = bsy_dst & ~hit_dst;
  assign op1    = (id_rs == '0) ? '0 : (hit_rs ? wb_data : rf_rd1);
  assign op2    = (id_rt == '0) ? '0 : (hit_rt ? wb_data : rf_rd2);
`else
  logic unused_bypass;
  assign unused_bypass = ^{wb_data, hit_rs, hit_rt, hit_dst};
  assign eb_rs  = bsy_rs;
  assign eb_rt  = bsy_rt;
  assign eb_dst = bsy_dst;
  assign op1    = (id_rs == '0) ? '0 : rf_rd1;
  assign op2    = (id_rt == '0) ? '0 : rf_rd2;
`endif

  assign hazard   = id_valid & (eb_rs | eb_rt | (id_dst_we & eb_dst));
  assign out_free = ~ex_valid_q | ex_ready;
  assign id_ready = ~hazard & out_free;
  assign accept   = id_valid & id_ready;
  assign stall    = id_valid & ~id_ready;

  // Clear before set so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (wb_we && (wb_addr == AW'(i))) busy_d[i] = 1'b0;
      if (accept && id_dst_we && (id_dst == AW'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (id_valid && hazard)           state_d = StRawWait;
        else if (id_valid && !out_free)   state_d = StOutWait;
      end
      StRawWait: begin
        if (accept || !id_valid)          state_d = StRun;
        else if (!hazard && !out_free)    state_d = StOutWait;
      end
      StOutWait: begin
        if (accept || !id_valid)          state_d = StRun;
        else if (hazard)                  state_d = StRawWait;
      end
      default:                            state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= StRun;
      busy_q      <= '0;
      ex_valid_q  <= 1'b0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      ex_dst_q    <= '0;
      ex_dst_we_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ex_valid_q  <= 1'b1;
        ex_op1_q    <= op1;
        ex_op2_q    <= op2;
        ex_dst_q    <= id_dst;
        ex_dst_we_q <= id_dst_we;
      end else if (ex_ready) begin
        ex_valid_q  <= 1'b0;
      end
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_op1    = ex_op1_q;
  assign ex_op2    = ex_op2_q;
  assign ex_dst    = ex_dst_q;
  assign ex_dst_we = ex_dst_we_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Directed bench for reg_read_scoreboard: a per-cycle behavioural model plus literal spot checks.
module tb_reg_read_scoreboard;
  localparam int CW = 8;
`ifdef RRS_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int EXP_CNT2 = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int EXP_CNT2 = 2;
`endif

  logic CLK = 1'b0, reset = 1'b1;
  logic id_valid = 0, id_ready, id_dst_we = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dst = 0, rf_rs, rf_rt, wb_addr = 0, ex_dst;
  logic [31:0] rf_rd1, rf_rd2, wb_data = 0, ex_op1, ex_op2;
  logic wb_we = 0, ex_valid, ex_ready = 1, ex_dst_we;
  logic [CW-1:0] stall_cnt;
  logic [31:0] rf [32];

  int checks = 0, failures = 0;
  bit model_on = 0;

  bit m_busy [32];
  bit m_ex_valid, m_dst_we;
  logic [31:0] m_op1, m_op2;
  logic [4:0] m_dst;
  int m_cnt;

  reg_read_scoreboard #(.NREG(32), .AW(5), .DW(32), .CNT_W(CW)) dut (
    .CLK(CLK), .reset(reset), .id_valid(id_valid), .id_ready(id_ready), .id_rs(id_rs),
    .id_rt(id_rt), .id_dst(id_dst), .id_dst_we(id_dst_we), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_dst(ex_dst), .ex_dst_we(ex_dst_we), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  // Register file environment: reg i holds i*0x11 after reset; reg 0 is never written.
  always @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h11 * i;
    end else if (wb_we && wb_addr != 0) begin
      rf[wb_addr] <= wb_data;
    end
  end
  assign rf_rd1 = rf[rf_rs];
  assign rf_rd2 = rf[rf_rt];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // A source is pending if an earlier accepted write to it has not yet been written back
  // (a same-cycle writeback releases it only when bypass is available).
  function automatic bit pending(input logic [4:0] r);
    return (r != 0) && m_busy[r] && !(BYP && wb_we && wb_addr == r);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (BYP && wb_we && wb_addr == r) return wb_data;
    return rf[r];
  endfunction

  always @(negedge CLK) begin : model
    bit hz, rdy, acc;
    hz  = id_valid && (pending(id_rs) || pending(id_rt) || (id_dst_we && pending(id_dst)));
    rdy = !hz && (!m_ex_valid || ex_ready);
    acc = id_valid && rdy;
    if (model_on) begin
      chk("id_ready", {31'b0, id_ready}, {31'b0, rdy});
      chk("rf_rs", {27'b0, rf_rs}, {27'b0, id_rs});
      chk("rf_rt", {27'b0, rf_rt}, {27'b0, id_rt});
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_ex_valid});
      chk("ex_op1", ex_op1, m_op1);
      chk("ex_op2", ex_op2, m_op2);
      chk("ex_dst", {27'b0, ex_dst}, {27'b0, m_dst});
      chk("ex_dst_we", {31'b0, ex_dst_we}, {31'b0, m_dst_we});
      chk("stall_cnt", {24'b0, stall_cnt}, m_cnt);
    end
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_ex_valid = 0; m_op1 = 0; m_op2 = 0; m_dst = 0; m_dst_we = 0; m_cnt = 0;
    end else begin
      if (id_valid && !rdy && m_cnt != (1 << CW) - 1) m_cnt++;
      if (wb_we && wb_addr != 0) m_busy[wb_addr] = 0;
      if (acc && id_dst_we && id_dst != 0) m_busy[id_dst] = 1;
      if (acc) begin
        m_ex_valid = 1; m_op1 = operand(id_rs); m_op2 = operand(id_rt);
        m_dst = id_dst; m_dst_we = id_dst_we;
      end else if (ex_ready) begin
        m_ex_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic we);
    id_valid = 1; id_rs = rs; id_rt = rt; id_dst = dst; id_dst_we = we;
  endtask

  initial begin
    reset = 1;
    step(); step();
    model_on = 1;
    reset = 0;
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_stall_cnt", {24'b0, stall_cnt}, 32'h0);
    chk("rst_ex_op1", ex_op1, 32'h0);

    // 1: basic issue
    issue(1, 2, 3, 0);
    #1 chk("t1_ready", {31'b0, id_ready}, 32'h1);
    step();
    chk("t1_valid", {31'b0, ex_valid}, 32'h1);
    chk("t1_op1", ex_op1, 32'h11);
    chk("t1_op2", ex_op2, 32'h22);

    // 2: RAW on r5, resolved by writeback
    issue(0, 0, 5, 1);
    step();
    issue(5, 0, 6, 0);
    #1 chk("t2_raw_ready", {31'b0, id_ready}, 32'h0);
    step();
    wb_we = 1; wb_addr = 5; wb_data = 32'hABCD;
`ifdef RRS_BYPASS_EN
    #1 chk("t2_byp_ready", {31'b0, id_ready}, 32'h1);
    step();
    wb_we = 0;
`else
    #1 chk("t2_wb_ready", {31'b0, id_ready}, 32'h0);
    step();
    wb_we = 0;
    #1 chk("t2_late_ready", {31'b0, id_ready}, 32'h1);
    step();
`endif
    id_valid = 0;
    chk("t2_op1", ex_op1, 32'hABCD);
    chk("t2_cnt", {24'b0, stall_cnt}, EXP_CNT2);

    // 3: output back-pressure
    issue(1, 2, 0, 0);
    step();
    ex_ready = 0;
    issue(2, 1, 0, 0);
    #1 chk("t3_ready", {31'b0, id_ready}, 32'h0);
    step();
    chk("t3_hold_valid", {31'b0, ex_valid}, 32'h1);
    chk("t3_hold_op1", ex_op1, 32'h11);
    chk("t3_hold_op2", ex_op2, 32'h22);
    ex_ready = 1;
    #1 chk("t3_free_ready", {31'b0, id_ready}, 32'h1);
    step();
    chk("t3_new_op1", ex_op1, 32'h22);
    chk("t3_new_op2", ex_op2, 32'h11);

    // 4: register 0 never busy, never bypassed
    issue(3, 4, 0, 1);
    step();
    issue(0, 1, 2, 0);
    #1 chk("t4_ready", {31'b0, id_ready}, 32'h1);
    step();
    chk("t4_op1", ex_op1, 32'h0);
    chk("t4_op2", ex_op2, 32'h11);
    wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF;
    issue(0, 0, 2, 0);
    step();
    wb_we = 0;
    chk("t4_wb0_op1", ex_op1, 32'h0);
    chk("t4_wb0_op2", ex_op2, 32'h0);

    // 5: WAW on r7, set wins over same-cycle clear
    issue(0, 0, 7, 1);
    step();
    issue(0, 0, 7, 1);
    #1 chk("t5_waw_ready", {31'b0, id_ready}, 32'h0);
    step();
    wb_we = 1; wb_addr = 7; wb_data = 32'h77;
`ifdef RRS_BYPASS_EN
    #1 chk("t5_byp_ready", {31'b0, id_ready}, 32'h1);
    step();
    wb_we = 0;
`else
    step();
    wb_we = 0;
    #1 chk("t5_late_ready", {31'b0, id_ready}, 32'h1);
    step();
`endif
    chk("t5_dst", {27'b0, ex_dst}, 32'h7);
    issue(7, 0, 1, 0);
    #1 chk("t5_busy7", {31'b0, id_ready}, 32'h0);
    id_valid = 0;
    wb_we = 1; wb_addr = 7; wb_data = 32'h77;
    step();
    wb_we = 0;

    // 6: long stall saturates, then reset mid-stall
    issue(0, 0, 9, 1);
    step();
    ex_ready = 0;
    issue(9, 0, 1, 0);
    repeat ((1 << CW) + 5) step();
    chk("t6_sat", {24'b0, stall_cnt}, 32'hFF);
    reset = 1;
    step();
    chk("t6_rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("t6_rst_cnt", {24'b0, stall_cnt}, 32'h0);
    reset = 0; ex_ready = 1;
    #1 chk("t6_busy_clr", {31'b0, id_ready}, 32'h1);
    step();
    chk("t6_reissue", {31'b0, ex_valid}, 32'h1);
    chk("t6_op1", ex_op1, 32'h99);
    id_valid = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
